spi_config_sequencer: RTL and testbench
=======================================

# spi_config_sequencer

Parametrised SPI register-configuration sequencer for image-sensor and ADC front ends. After reset, or on a start request, it walks a register table supplied by the parent through a lookup port and writes each entry over its own SPI mode-0 master. It can optionally read each register back and compare it, retrying a mismatching entry a bounded number of times. It reports busy/done/error status to the capture pipeline, which holds off streaming until configuration completes.

## Interface
- NUM_REGS, 5: number of table entries, indices 0..NUM_REGS-1 (≥1)
- ADDR_WIDTH, 7: register address field width
- DATA_WIDTH, 8: register data field width
- NUM_SLAVES, 2: number of chip selects
- CLK_DIV, 4: clk cycles per sclk half-period (≥2)
- VERIFY, 1: 1 = read back and compare each entry after writing it
- MAX_RETRIES, 3: extra write attempts per entry on mismatch (0 = none)
- START_ON_RESET, 1: 1 = begin the sequence automatically on the first cycle after reset release
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  single-cycle sequence request
- cfg_index  out  clog2(NUM_REGS)  table index being fetched
- cfg_addr  in  ADDR_WIDTH  register address for cfg_index (combinational lookup, same cycle)
- cfg_data  in  DATA_WIDTH  register value for cfg_index
- cfg_slave  in  clog2(NUM_SLAVES)  target chip select for cfg_index
- sclk  out  1  SPI clock, idles low
- mosi  out  1  SPI data out, MSB first
- miso  in  1  SPI data in
- ss_n  out  NUM_SLAVES  active-low chip selects
- busy  out  1  sequence in progress
- done  out  1  all entries written (and verified); sticky until next start
- error  out  1  sequence aborted; sticky until next start
- err_index  out  clog2(NUM_REGS)  entry that caused the abort

## Operation
- Frame: FRAME_LEN = 1+ADDR_WIDTH+DATA_WIDTH bits, sent as {rw, addr, data}. rw=1 for write, rw=0 for read.
- On a read frame, the data bits on mosi are 0 and miso is shifted into the read register during the data phase.
- States: IDLE, LOAD, WRITE, WGAP, READ, RGAP, CHECK, DONE, ERR.
- IDLE →LOAD on start, or on the first cycle after reset when START_ON_RESET=1. Entry to LOAD clears done, error, cfg_index and the retry count, and sets busy=1.
- LOAD: cfg_addr, cfg_data and cfg_slave are latched into a shadow register.
  - cfg_slave ≥ NUM_SLAVES →ERR with err_index=cfg_index; no frame is sent.
  - Otherwise →WRITE.
- WRITE →WGAP at frame end.
- WGAP →READ if VERIFY=1, else →CHECK.
- READ →RGAP →CHECK.
- CHECK (VERIFY=1), read data equals shadow data:
  - cfg_index = NUM_REGS-1 →DONE.
  - Otherwise cfg_index +1, retry count cleared, →LOAD.
- CHECK (VERIFY=1), read data differs:
  - retry count < MAX_RETRIES: retry count +1, →WRITE with the same shadow entry (no re-fetch).
  - Otherwise →ERR with err_index=cfg_index.
- CHECK (VERIFY=0): always treated as a match.
- DONE: done=1, busy=0. ERR: error=1, busy=0. start in either state →LOAD.
- start while busy is ignored.
- Only ss_n[shadow slave] asserts; all other chip selects stay high.

## Timing
- Reset values: sclk=0, mosi=0, ss_n=all 1, busy=0, done=0, error=0, cfg_index=0, err_index=0; state IDLE.
- Reset asserted mid-frame: outputs take the reset values on the next edge and the frame is truncated.
- start high in cycle k → LOAD in cycle k+1 → ss_n low from cycle k+2.
- Frame sequence:
  - ss_n falls; setup of CLK_DIV cycles with sclk=0 and mosi=first bit.
  - FRAME_LEN bit periods of 2·CLK_DIV cycles each, sclk low then high.
  - mosi changes only on the sclk falling edge (and at ss_n fall).
  - miso is sampled in the cycle sclk rises.
  - Hold of CLK_DIV cycles with sclk=0, then ss_n rises.
- ss_n low time per frame = CLK_DIV·(2·FRAME_LEN+2) cycles.
- WGAP/RGAP hold ss_n high for CLK_DIV cycles.
- CHECK and LOAD take 1 cycle each.
- done/error assert in the cycle after the final CHECK. busy falls in the same cycle.

## Test plan
- Defaults apart from CLK_DIV=2, VERIFY=0, START_ON_RESET=1; table {0x13:0x05, 0x32:0x02, 0x40:0x03, 0x1F:0x09, 0x29:0x01}, slave 0:
  - exactly 5 frames on ss_n[0], each 68 cycles low.
  - First frame bits 1_0010011_00000101.
  - done=1 and busy=0 after the fifth frame; ss_n[1] never low.
- VERIFY=1, miso model echoes the last written value: 10 frames, alternating rw=1/rw=0 per address; done=1, error=0.
- VERIFY=1, MAX_RETRIES=2, model returns 0xFF for entry 2:
  - entry 2 written 3 times and read 3 times.
  - error=1, err_index=2, done=0; no frame for entry 3.
- Model corrupts entry 1 only on the first read: entry 1 written twice, then the sequence continues to done=1.
- cfg_slave=3 with NUM_SLAVES=2 at entry 0: no ss_n activity, error=1, err_index=0.
- Reset pulsed mid-frame of entry 1:
  - next cycle ss_n=all 1, sclk=0, busy=0.
  - with START_ON_RESET=1 the restart begins at cfg_index=0.
  - start during busy has no effect.

Source files
------------

// File: rtl/spi_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spi_config_sequencer
// Purpose  : Walks a parent-supplied register table and writes each entry over
//            a mode-0 SPI master, with optional read-back check and retries.
// Revision : 1.0
// ============================================================================
module spi_config_sequencer #(
   parameter int NUM_REGS       = 5,
   parameter int ADDR_WIDTH     = 7,
   parameter int DATA_WIDTH     = 8,
   parameter int NUM_SLAVES     = 2,
   parameter int CLK_DIV        = 4,
   parameter int VERIFY         = 1,
   parameter int MAX_RETRIES    = 3,
   parameter int START_ON_RESET = 1,
   localparam int IW = (NUM_REGS   > 1) ? $clog2(NUM_REGS)   : 1,
   localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   output logic [IW-1:0]         cfg_index,
   input  logic [ADDR_WIDTH-1:0] cfg_addr,
   input  logic [DATA_WIDTH-1:0] cfg_data,
   input  logic [SW-1:0]         cfg_slave,
   output logic                  sclk,
   output logic                  mosi,
   input  logic                  miso,
   output logic [NUM_SLAVES-1:0] ss_n,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [IW-1:0]         err_index
);
   localparam int c_frame_len = 1 + ADDR_WIDTH + DATA_WIDTH;
   localparam int c_pw        = $clog2(2 * c_frame_len + 2);
   localparam int c_dw        = $clog2(CLK_DIV);
   localparam int c_rw        = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam logic [c_pw-1:0]       c_ph_last    = c_pw'(2 * c_frame_len + 1);
   localparam logic [c_pw-1:0]       c_last_bit   = c_pw'(c_frame_len - 1);
   localparam logic [c_pw-1:0]       c_first_data = c_pw'(1 + ADDR_WIDTH);
   localparam logic [c_dw-1:0]       c_div_last   = c_dw'(CLK_DIV - 1);
   localparam logic [c_rw-1:0]       c_retry_max  = c_rw'(MAX_RETRIES);
   localparam logic [IW-1:0]         c_last_idx   = IW'(NUM_REGS - 1);
   localparam logic [31:0]           c_slave_lim  = 32'(NUM_SLAVES);
   localparam logic [NUM_SLAVES-1:0] c_one_hot    = NUM_SLAVES'(1);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0, S_LOAD = 4'd1, S_WRITE = 4'd2, S_WGAP = 4'd3, S_READ = 4'd4,
      S_RGAP  = 4'd5, S_CHECK = 4'd6, S_DONE = 4'd7, S_ERR  = 4'd8
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  r_armed;
   logic [IW-1:0]         r_index;
   logic [IW-1:0]         r_err_index;
   logic [c_rw-1:0]       r_retry;
   logic [c_dw-1:0]       r_div;
   logic [c_pw-1:0]       r_ph;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;
   logic [SW-1:0]         r_slave;
   logic [DATA_WIDTH-1:0] r_rx;

   logic                   w_in_frame;
   logic                   w_timed;
   logic                   w_tick;
   logic                   w_rw;
   logic                   w_match;
   logic                   w_slave_bad;
   logic                   w_sample;
   logic                   w_restart;
   logic [c_pw-1:0]        w_bit;
   logic [c_frame_len-1:0] w_word;
   logic [c_frame_len-1:0] w_shift;

   assign cfg_index = r_index;
   assign err_index = r_err_index;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_in_frame  = (r_state == S_WRITE) || (r_state == S_READ);
      w_timed     = w_in_frame || (r_state == S_WGAP) || (r_state == S_RGAP);
      w_tick      = (r_div == c_div_last);
      w_rw        = (r_state == S_WRITE);
      w_match     = (VERIFY == 0) || (r_rx == r_data);
      w_slave_bad = (32'(cfg_slave) >= c_slave_lim);
      w_bit       = '0;
      if (r_ph != '0) begin
         w_bit = (r_ph - 1'b1) >> 1;
      end
      if (w_bit > c_last_bit) begin
         w_bit = c_last_bit;
      end
      // miso is taken on the edge that ends a low half-period, i.e. as sclk rises
      w_sample = (r_state == S_READ) && w_tick && r_ph[0] && (r_ph != c_ph_last)
                 && (w_bit >= c_first_data);
      w_word   = {w_rw, r_addr, r_data & {DATA_WIDTH{w_rw}}};
      w_shift  = w_word << w_bit;
      mosi     = w_in_frame && w_shift[c_frame_len-1];
      sclk     = w_in_frame && (r_ph != '0) && !r_ph[0];
      ss_n     = w_in_frame ? ~(c_one_hot << r_slave) : '1;
      busy     = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);
      done     = (r_state == S_DONE);
      error    = (r_state == S_ERR);

      case (r_state)
         S_IDLE:  if (start || r_armed) w_next = S_LOAD;
         S_LOAD:  w_next = w_slave_bad ? S_ERR : S_WRITE;
         S_WRITE: if (w_tick && (r_ph == c_ph_last)) w_next = S_WGAP;
         S_WGAP:  if (w_tick) w_next = (VERIFY != 0) ? S_READ : S_CHECK;
         S_READ:  if (w_tick && (r_ph == c_ph_last)) w_next = S_RGAP;
         S_RGAP:  if (w_tick) w_next = S_CHECK;
         S_CHECK: begin
            if (w_match) begin
               w_next = (r_index == c_last_idx) ? S_DONE : S_LOAD;
            end else if (r_retry < c_retry_max) begin
               w_next = S_WRITE;
            end else begin
               w_next = S_ERR;
            end
         end
         S_DONE, S_ERR: if (start) w_next = S_LOAD;
         default: w_next = S_IDLE;
      endcase
      w_restart = (w_next == S_LOAD) && (r_state != S_CHECK);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_armed     <= (START_ON_RESET != 0);
         r_index     <= '0;
         r_err_index <= '0;
         r_retry     <= '0;
         r_div       <= '0;
         r_ph        <= '0;
         r_addr      <= '0;
         r_data      <= '0;
         r_slave     <= '0;
         r_rx        <= '0;
      end else begin
         r_armed <= 1'b0;
         // Every state change restarts the half-period timing from zero
         if (w_next != r_state) begin
            r_div <= '0;
            r_ph  <= '0;
         end else if (w_timed) begin
            if (w_tick) begin
               r_div <= '0;
               r_ph  <= r_ph + 1'b1;
            end else begin
               r_div <= r_div + 1'b1;
            end
         end
         if (w_restart) begin
            r_index <= '0;
            r_retry <= '0;
         end
         if (r_state == S_LOAD) begin
            r_addr  <= cfg_addr;
            r_data  <= cfg_data;
            r_slave <= cfg_slave;
            if (w_slave_bad) r_err_index <= r_index;
         end
         if (r_state == S_CHECK) begin
            if (w_next == S_LOAD) begin
               r_index <= r_index + 1'b1;
               r_retry <= '0;
            end else if (w_next == S_WRITE) begin
               r_retry <= r_retry + 1'b1;
            end else if (w_next == S_ERR) begin
               r_err_index <= r_index;
            end
         end
         if (w_sample) r_rx <= DATA_WIDTH'({r_rx, miso});
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_config_sequencer
// Purpose  : Directed and randomized checks of spi_config_sequencer against a
//            table-walking reference model and an SPI slave model.
// Revision : 1.0
// ============================================================================
module tb_spi_config_sequencer;
   localparam int NREG = 5;
   localparam int AW   = 7;
   localparam int DWD  = 8;
   localparam int NSLV = 3;
   localparam int DIV  = 2;
   localparam int MAXR = 2;
   localparam int FL   = 1 + AW + DWD;
   localparam int LOWT = DIV * (2 * FL + 2);

   logic            clk     = 1'b0;
   logic            reset_n = 1'b0;
   logic            start   = 1'b0;
   logic            miso    = 1'b0;
   logic [2:0]      cfg_index;
   logic [AW-1:0]   cfg_addr;
   logic [DWD-1:0]  cfg_data;
   logic [1:0]      cfg_slave;
   logic            sclk, mosi, busy, done, error;
   logic [NSLV-1:0] ss_n;
   logic [2:0]      err_index;

   spi_config_sequencer #(
      .NUM_REGS(NREG), .ADDR_WIDTH(AW), .DATA_WIDTH(DWD), .NUM_SLAVES(NSLV),
      .CLK_DIV(DIV), .VERIFY(1), .MAX_RETRIES(MAXR), .START_ON_RESET(1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .cfg_index(cfg_index),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_slave(cfg_slave),
      .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n), .busy(busy),
      .done(done), .error(error), .err_index(err_index)
   );

   always #5 clk = ~clk;

   // Register table served to the DUT
   logic [AW-1:0]  tb_addr  [NREG];
   logic [DWD-1:0] tb_data  [NREG];
   logic [1:0]     tb_slave [NREG];
   int             bad_n    [NREG];

   always_comb begin
      cfg_addr  = '0;
      cfg_data  = '0;
      cfg_slave = '0;
      if (int'(cfg_index) < NREG) begin
         cfg_addr  = tb_addr[cfg_index];
         cfg_data  = tb_data[cfg_index];
         cfg_slave = tb_slave[cfg_index];
      end
   end

   // SPI slave model and bus monitor
   bit [DWD-1:0]    mem [4][128];
   int              reads_seen [128] = '{default: 0};
   int              bad_upto   [128] = '{default: 0};
   logic [FL-1:0]   mon_bits [$];
   int              mon_slv  [$];
   int              mon_nb   [$];
   int              mon_low  [$];
   logic [NSLV-1:0] prev_ss   = '1;
   logic            prev_sclk = 1'b0;
   int              nb, lowc, cslv, last_rise, cyc = 0, multi_sel = 0;
   logic [FL-1:0]   sh;
   logic [DWD-1:0]  resp;
   bit              rd;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if ($countones(~ss_n) > 1) multi_sel++;
      if (ss_n != '1) begin
         if (prev_ss == '1) begin
            nb = 0; lowc = 0; sh = '0; rd = 1'b0; cslv = 0;
            for (int s = 0; s < NSLV; s++) if (!ss_n[s]) cslv = s;
         end
         lowc++;
         if (sclk && !prev_sclk) begin
            sh = {sh[FL-2:0], mosi};
            nb++;
            if (nb == 1 + AW && !sh[AW]) begin
               rd   = 1'b1;
               resp = mem[cslv][sh[AW-1:0]];
               if (reads_seen[sh[AW-1:0]] < bad_upto[sh[AW-1:0]]) resp = ~resp;
               reads_seen[sh[AW-1:0]]++;
            end
         end
         if (!sclk && prev_sclk && rd && nb >= 1 + AW && nb < FL) miso = resp[FL-1-nb];
      end else if (prev_ss != '1) begin
         mon_bits.push_back(sh);
         mon_slv.push_back(cslv);
         mon_nb.push_back(nb);
         mon_low.push_back(lowc);
         last_rise = cyc;
         if (nb == FL && sh[FL-1]) mem[cslv][sh[FL-2:DWD]] = sh[DWD-1:0];
         miso = 1'b0;
      end
      prev_ss   = ss_n;
      prev_sclk = sclk;
   end

   // Checking helpers and reference model
   int            n_tests = 0;
   int            n_fail  = 0;
   logic [FL-1:0] exp_bits [$];
   int            exp_slv  [$];
   bit            exp_err, exp_load_abort, dup;
   int            exp_eidx, base;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   // Each entry: attempt t writes then reads; read t is corrupt iff t < bad_n.
   task automatic build_model();
      exp_bits.delete();
      exp_slv.delete();
      exp_err = 1'b0; exp_eidx = 0; exp_load_abort = 1'b0;
      for (int e = 0; e < NREG && !exp_err; e++) begin
         if (int'(tb_slave[e]) >= NSLV) begin
            exp_err = 1'b1; exp_eidx = e; exp_load_abort = 1'b1;
         end else begin
            for (int t = 0; t <= MAXR; t++) begin
               exp_bits.push_back({1'b1, tb_addr[e], tb_data[e]});
               exp_slv.push_back(int'(tb_slave[e]));
               exp_bits.push_back({1'b0, tb_addr[e], {DWD{1'b0}}});
               exp_slv.push_back(int'(tb_slave[e]));
               if (t >= bad_n[e]) break;
               if (t == MAXR) begin
                  exp_err = 1'b1; exp_eidx = e;
               end
            end
         end
      end
   endtask

   task automatic arm_bad();
      for (int e = 0; e < NREG; e++) bad_upto[tb_addr[e]] = reads_seen[tb_addr[e]] + bad_n[e];
   endtask

   task automatic set_directed();
      tb_addr = '{7'h13, 7'h32, 7'h40, 7'h1F, 7'h29};
      tb_data = '{8'h05, 8'h02, 8'h03, 8'h09, 8'h01};
      for (int e = 0; e < NREG; e++) begin
         tb_slave[e] = 2'd0;
         bad_n[e]    = 0;
      end
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic run_and_check(input string tag, input int b);
      bit ok;
      int got, done_cyc;
      ok = 1'b0;
      done_cyc = 0;
      for (int i = 0; i < 8000 && !ok; i++) begin
         @(negedge clk);
         if (done || error) begin
            ok = 1'b1;
            done_cyc = cyc;
         end
      end
      check({tag, " finished"}, 32'(ok), 32'd1);
      got = mon_bits.size() - b;
      check({tag, " frame count"}, got, exp_bits.size());
      for (int i = 0; i < exp_bits.size() && i < got; i++) begin
         check($sformatf("%s f%0d bits", tag, i), 32'(mon_bits[b+i]), 32'(exp_bits[i]));
         check($sformatf("%s f%0d slave", tag, i), mon_slv[b+i], exp_slv[i]);
         check($sformatf("%s f%0d nbits", tag, i), mon_nb[b+i], FL);
         check($sformatf("%s f%0d low", tag, i), mon_low[b+i], LOWT);
      end
      if (got > 0 && !exp_load_abort)
         check({tag, " status latency"}, done_cyc - last_rise, DIV + 1);
      check({tag, " done"}, 32'(done), 32'(!exp_err));
      check({tag, " error"}, 32'(error), 32'(exp_err));
      check({tag, " busy"}, 32'(busy), 32'd0);
      if (exp_err) check({tag, " err_index"}, 32'(err_index), exp_eidx);
   endtask

   initial begin
      // Reset values, then automatic start on release
      set_directed();
      arm_bad();
      repeat (3) @(negedge clk);
      check("rst sclk", 32'(sclk), 32'd0);
      check("rst mosi", 32'(mosi), 32'd0);
      check("rst ss_n", 32'(ss_n), 32'h7);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst error", 32'(error), 32'd0);
      check("rst cfg_index", 32'(cfg_index), 32'd0);
      check("rst err_index", 32'(err_index), 32'd0);
      reset_n = 1'b1;
      build_model();
      run_and_check("echo", 0);
      check("first frame", (mon_bits.size() > 0) ? 32'(mon_bits[0]) : 32'hDEAD, 32'h9305);

      // Entry 1 corrupted on its first read only; also start-to-ss_n latency
      bad_n[1] = 1;
      arm_bad();
      build_model();
      base = mon_bits.size();
      pulse_start();
      check("load busy", 32'(busy), 32'd1);
      check("load ss_n", 32'(ss_n), 32'h7);
      check("load cfg_index", 32'(cfg_index), 32'd0);
      @(negedge clk);
      check("frame ss_n", 32'(ss_n), 32'h6);
      check("frame setup sclk", 32'(sclk), 32'd0);
      check("frame setup mosi", 32'(mosi), 32'd1);
      run_and_check("retry once", base);

      // Entry 2 never reads back correctly
      bad_n[1] = 0;
      bad_n[2] = 99;
      arm_bad();
      build_model();
      base = mon_bits.size();
      pulse_start();
      run_and_check("retry exhaust", base);
      bad_n[2] = 0;
      arm_bad();

      // Out-of-range chip select at entry 0
      tb_slave[0] = 2'd3;
      build_model();
      base = mon_bits.size();
      pulse_start();
      run_and_check("bad slave", base);
      tb_slave[0] = 2'd0;

      // Reset in the middle of entry 1, auto-restart, start while busy ignored
      pulse_start();
      dup = 1'b0;
      for (int i = 0; i < 3000 && !dup; i++) begin
         @(negedge clk);
         if (cfg_index == 3'd1 && ss_n != '1) dup = 1'b1;
      end
      check("reach entry 1", 32'(dup), 32'd1);
      repeat (20) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check("midrst ss_n", 32'(ss_n), 32'h7);
      check("midrst sclk", 32'(sclk), 32'd0);
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst cfg_index", 32'(cfg_index), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("restart busy", 32'(busy), 32'd1);
      check("restart cfg_index", 32'(cfg_index), 32'd0);
      base = mon_bits.size();
      build_model();
      repeat (150) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      run_and_check("restart", base);

      // Randomized tables, chip selects and read corruption
      for (int r = 0; r < 8; r++) begin
         for (int e = 0; e < NREG; e++) begin
            do begin
               tb_addr[e] = 7'($urandom_range(0, 127));
               dup = 1'b0;
               for (int j = 0; j < e; j++) if (tb_addr[j] == tb_addr[e]) dup = 1'b1;
            end while (dup);
            tb_data[e]  = 8'($urandom_range(0, 255));
            tb_slave[e] = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            bad_n[e]    = $urandom_range(0, 6);
            if (bad_n[e] > 3) bad_n[e] = 0;
         end
         arm_bad();
         build_model();
         base = mon_bits.size();
         pulse_start();
         run_and_check($sformatf("rand%0d", r), base);
      end

      check("single chip select", multi_sel, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
